// File: rtl/histo_pkg.sv
// histo_pkg: widths and FSM encoding shared by the histogram writer and displayer
package histo_pkg;
  localparam int PIX_W = 8;
  localparam int CNT_W = 20;
  localparam int NUM_BINS = 2 ** PIX_W;
  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DRAIN} state_t;
endpackage

// File: rtl/histo_rmw_pipe.sv
// histo_rmw_pipe: per-pixel read-modify-write with write forwarding, saturating
// increment and running peak tracking
module histo_rmw_pipe
  import histo_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             max_clr,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_addr,
  input  logic [CNT_W-1:0] rd_data,
  output logic             wr_en,
  output logic [PIX_W-1:0] wr_addr,
  output logic [CNT_W-1:0] wr_data,
  output logic [CNT_W-1:0] max_val_nxt,
  output logic [PIX_W-1:0] max_bin_nxt
);
  logic s1_valid_q, s1_valid_d, lw_valid_q, lw_valid_d;
  logic [PIX_W-1:0] s1_addr_q, s1_addr_d, lw_addr_q, lw_addr_d, max_bin_q, max_bin_d;
  logic [CNT_W-1:0] lw_data_q, lw_data_d, max_val_q, max_val_d, base, count;
  logic bump;
  always_comb begin
    // the RAM returns pre-write data when last cycle's write hit the same bin
    base = (lw_valid_q && lw_addr_q == s1_addr_q) ? lw_data_q : rd_data;
    count = (&base) ? base : base + 1'b1;
    bump = s1_valid_q && count > max_val_q;
    s1_valid_d = in_valid && !flush;
    s1_addr_d = in_valid ? in_addr : s1_addr_q;
    lw_valid_d = s1_valid_q && !flush;
    lw_addr_d = s1_addr_q;
    lw_data_d = count;
    max_val_d = max_clr ? '0 : bump ? count : max_val_q;
    max_bin_d = max_clr ? '0 : bump ? s1_addr_q : max_bin_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_addr_q <= '0;
      lw_valid_q <= 1'b0;
      lw_addr_q <= '0;
      lw_data_q <= '0;
      max_val_q <= '0;
      max_bin_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_addr_q <= s1_addr_d;
      lw_valid_q <= lw_valid_d;
      lw_addr_q <= lw_addr_d;
      lw_data_q <= lw_data_d;
      max_val_q <= max_val_d;
      max_bin_q <= max_bin_d;
    end
  end
  assign wr_en = s1_valid_q;
  assign wr_addr = s1_addr_q;
  assign wr_data = s1_valid_q ? count : '0;
  assign max_val_nxt = max_val_d;
  assign max_bin_nxt = max_bin_d;
endmodule

// File: rtl/histogram_accumulator.sv
// histogram_accumulator: clears the histogram RAM, accumulates one frame of
// pixels into it and publishes the peak bin when the last write has retired
module histogram_accumulator
  import histo_pkg::*;
(
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iFrameStart,
  input  logic             iFrameEnd,
  input  logic             iValid,
  input  logic [PIX_W-1:0] iPixel,
  output logic             oReady,
  output logic [PIX_W-1:0] oRdAddr,
  input  logic [CNT_W-1:0] iRdData,
  output logic [PIX_W-1:0] oWrAddr,
  output logic [CNT_W-1:0] oWrData,
  output logic             oWrEn,
  output logic [CNT_W-1:0] oMaxValue,
  output logic [PIX_W-1:0] oMaxBin,
  output logic             oDone,
  output logic             oBusy
);
  state_t state_q, state_d;
  logic [PIX_W-1:0] clr_addr_q, clr_addr_d, rd_addr_q, rd_addr_d, max_bin_q, max_bin_d;
  logic [PIX_W-1:0] pipe_addr, pipe_max_bin;
  logic [CNT_W-1:0] max_val_q, max_val_d, pipe_data, pipe_max_val;
  logic done_q, done_d, accept, clearing, pipe_wr;
  always_comb begin
    clearing = state_q == CLEAR;
    accept = iValid && state_q == ACCUM;
    state_d = iFrameStart ? CLEAR
            : (clearing && &clr_addr_q) ? ACCUM
            : (state_q == ACCUM && iFrameEnd) ? DRAIN
            : state_q == DRAIN ? IDLE : state_q;
    clr_addr_d = iFrameStart ? '0 : clearing ? clr_addr_q + 1'b1 : clr_addr_q;
    rd_addr_d = accept ? iPixel : rd_addr_q;
    // nothing is accepted in DRAIN, so stage 1's write retires at this edge
    done_d = state_q == DRAIN && !iFrameStart;
    max_val_d = done_d ? pipe_max_val : max_val_q;
    max_bin_d = done_d ? pipe_max_bin : max_bin_q;
  end
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      clr_addr_q <= '0;
      rd_addr_q <= '0;
      done_q <= 1'b0;
      max_val_q <= '0;
      max_bin_q <= '0;
    end else begin
      state_q <= state_d;
      clr_addr_q <= clr_addr_d;
      rd_addr_q <= rd_addr_d;
      done_q <= done_d;
      max_val_q <= max_val_d;
      max_bin_q <= max_bin_d;
    end
  end
  histo_rmw_pipe u_pipe (
    .clk(iClk),
    .rst_n(iRst_n),
    .flush(iFrameStart && state_q != IDLE),
    .max_clr(clearing),
    .in_valid(accept),
    .in_addr(iPixel),
    .rd_data(iRdData),
    .wr_en(pipe_wr),
    .wr_addr(pipe_addr),
    .wr_data(pipe_data),
    .max_val_nxt(pipe_max_val),
    .max_bin_nxt(pipe_max_bin)
  );
  assign oReady = state_q == ACCUM;
  assign oBusy = state_q != IDLE;
  assign oRdAddr = accept ? iPixel : rd_addr_q;
  assign oWrEn = clearing || pipe_wr;
  assign oWrAddr = clearing ? clr_addr_q : pipe_addr;
  assign oWrData = clearing ? '0 : pipe_data;
  assign oDone = done_q;
  assign oMaxValue = max_val_q;
  assign oMaxBin = max_bin_q;
endmodule

// File: tb/tb_histogram_accumulator.sv
// tb_histogram_accumulator: randomized frames against a per-bin count model with a RAM model
module tb_histogram_accumulator;
  import histo_pkg::*;
  localparam int SAT = 2 ** CNT_W - 1;
  logic iClk = 0, iRst_n = 0, iFrameStart = 0, iFrameEnd = 0, iValid = 0;
  logic [PIX_W-1:0] iPixel = '0;
  logic oReady, oWrEn, oDone, oBusy;
  logic [PIX_W-1:0] oRdAddr, oWrAddr, oMaxBin;
  logic [CNT_W-1:0] iRdData, oWrData, oMaxValue;
  logic [CNT_W-1:0] ram [NUM_BINS];
  logic preload_en = 0;
  logic [PIX_W-1:0] preload_addr = '0;
  logic [CNT_W-1:0] preload_val = '0;
  int checks = 0, failures = 0, cyc = 0, last_acc_cyc = -1;
  int ref_cnt [NUM_BINS];
  int ref_max = 0, ref_bin = 0, exp_max_val = 0, exp_max_bin = 0;
  int px_q [$];

  histogram_accumulator dut (
    .iClk(iClk), .iRst_n(iRst_n), .iFrameStart(iFrameStart), .iFrameEnd(iFrameEnd),
    .iValid(iValid), .iPixel(iPixel), .oReady(oReady), .oRdAddr(oRdAddr),
    .iRdData(iRdData), .oWrAddr(oWrAddr), .oWrData(oWrData), .oWrEn(oWrEn),
    .oMaxValue(oMaxValue), .oMaxBin(oMaxBin), .oDone(oDone), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  // true dual-port RAM: registered read, old data on read-during-write
  always @(posedge iClk) begin
    cyc <= cyc + 1;
    if (preload_en) ram[preload_addr] <= preload_val;
    else if (oWrEn) ram[oWrAddr] <= oWrData;
    iRdData <= ram[oRdAddr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic model_reset();
    for (int b = 0; b < NUM_BINS; b++) ref_cnt[b] = 0;
    ref_max = 0;
    ref_bin = 0;
  endtask

  task automatic model_pix(input int p);
    if (ref_cnt[p] < SAT) ref_cnt[p]++;
    if (ref_cnt[p] > ref_max) begin
      ref_max = ref_cnt[p];
      ref_bin = p;
    end
  endtask

  task automatic gen(input int n, input int maxv, input int bubble_pct);
    px_q.delete();
    for (int i = 0; i < n; i++)
      px_q.push_back(($urandom_range(0, 99) < bubble_pct && i != n - 1) ? -1 : int'($urandom_range(0, maxv)));
  endtask

  task automatic start_frame();
    int bad = 0;
    iFrameStart = 1;
    step();
    iFrameStart = 0;
    model_reset();
    for (int i = 0; i < NUM_BINS; i++) begin
      @(negedge iClk);
      if (!oWrEn || int'(oWrAddr) != i || oWrData != 0 || oReady || !oBusy ||
          int'(oMaxValue) != exp_max_val || int'(oMaxBin) != exp_max_bin) bad++;
      step();
    end
    check("clear_sweep_errs", bad, 0);
    @(negedge iClk);
    check("accum_ready", oReady, 1);
    check("accum_busy", oBusy, 1);
    check("accum_no_write", oWrEn, 0);
    step();
  endtask

  task automatic send(input bit with_end);
    int bad = 0;
    for (int k = 0; k < px_q.size(); k++) begin
      iValid = px_q[k] >= 0;
      iPixel = px_q[k] >= 0 ? PIX_W'(px_q[k]) : PIX_W'($urandom);
      iFrameEnd = with_end && k == px_q.size() - 1;
      @(negedge iClk);
      if (!oReady || (iValid && oRdAddr != iPixel) || int'(oMaxValue) != exp_max_val) bad++;
      if (iValid) begin
        model_pix(px_q[k]);
        last_acc_cyc = cyc;
      end
      step();
    end
    iValid = 0;
    iFrameEnd = 0;
    check("stream_errs", bad, 0);
  endtask

  task automatic finish_frame(input string tag);
    int done_cyc = -1, pulses = 0, bad = 0, lat;
    for (int i = 0; i < 8; i++) begin
      @(negedge iClk);
      if (oDone) begin
        pulses++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc < 0 && int'(oMaxValue) != exp_max_val) bad++;
      step();
    end
    lat = done_cyc - last_acc_cyc;
    check({tag, "_done_pulses"}, pulses, 1);
    check({tag, "_done_latency_ok"}, done_cyc >= 0 && lat >= 1 && lat <= 2, 1);
    check({tag, "_max_held_before_done"}, bad, 0);
    exp_max_val = ref_max;
    exp_max_bin = ref_bin;
    check({tag, "_max_value"}, oMaxValue, ref_max);
    check({tag, "_max_bin"}, oMaxBin, ref_bin);
    check({tag, "_idle_after"}, oBusy, 0);
    bad = 0;
    for (int b = 0; b < NUM_BINS; b++) if (int'(ram[b]) != ref_cnt[b]) bad++;
    check({tag, "_bin_errs"}, bad, 0);
  endtask

  initial begin
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    check("rst_wren", oWrEn, 0);
    check("rst_ready", oReady, 0);
    check("rst_busy", oBusy, 0);
    check("rst_done", oDone, 0);
    check("rst_maxval", oMaxValue, 0);
    check("rst_maxbin", oMaxBin, 0);
    check("rst_wraddr", oWrAddr, 0);
    check("rst_wrdata", oWrData, 0);
    check("rst_rdaddr", oRdAddr, 0);
    step();
    iRst_n = 1;
    step();

    start_frame();
    px_q.delete();
    for (int i = 0; i < NUM_BINS; i++) px_q.push_back(i);
    send(1);
    finish_frame("ramp");
    check("ramp_max_is_1", oMaxValue, 1);
    check("ramp_bin_tie_0", oMaxBin, 0);

    start_frame();
    px_q.delete();
    repeat (1000) px_q.push_back(7);
    repeat (5) px_q.push_back(200);
    send(1);
    finish_frame("burst");
    check("burst_bin7", ram[7], 1000);
    check("burst_bin200", ram[200], 5);
    check("burst_maxbin", oMaxBin, 7);

    start_frame();
    px_q = '{9, -1, 9, 3, -1, 9};
    send(1);
    finish_frame("gapped");
    check("gapped_bin9", ram[9], 3);
    check("gapped_bin3", ram[3], 1);

    start_frame();
    preload_en = 1;
    preload_addr = 42;
    preload_val = CNT_W'(SAT - 1);
    ref_cnt[42] = SAT - 1;
    step();
    preload_en = 0;
    px_q = '{42, 42, 42};
    send(1);
    finish_frame("sat");
    check("sat_bin42", ram[42], SAT);
    check("sat_maxval", oMaxValue, SAT);

    start_frame();
    gen(50, 15, 0);
    send(0);
    start_frame();
    gen(300, 7, 25);
    send(1);
    finish_frame("after_abort");

    start_frame();
    gen(400, 255, 30);
    send(1);
    finish_frame("rand_wide");

    iFrameStart = 1;
    step();
    iFrameStart = 0;
    repeat (100) step();
    iRst_n = 0;
    #1;
    check("midclr_rst_wren", oWrEn, 0);
    check("midclr_rst_busy", oBusy, 0);
    check("midclr_rst_ready", oReady, 0);
    check("midclr_rst_maxval", oMaxValue, 0);
    check("midclr_rst_maxbin", oMaxBin, 0);
    check("midclr_rst_wraddr", oWrAddr, 0);
    check("midclr_rst_done", oDone, 0);
    step();
    iRst_n = 1;
    step();
    @(negedge iClk);
    check("midclr_idle_after", oBusy, 0);
    check("midclr_no_write_after", oWrEn, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/histogram_accumulator.md
Name: histogram_accumulator

Overview:
- Builds the per-frame 256-bin luminance histogram from the camera pixel stream into the histogram true dual-port RAM.
- It is the writer side of that RAM. HistogramDisplayer reads the RAM on its own port and takes the frame maximum from this block.
- Each frame it clears the RAM, does a read-modify-write per valid pixel, tracks the peak bin, and pulses done when the last write has retired.

Parameters:
- PIX_W, 8, pixel width; bin count = 2**PIX_W = 256.
- CNT_W, 20, bin counter width; counts saturate at 2**CNT_W-1 (800*480 = 384000 fits).

Ports:
- iClk  in  1  system clock
- iRst_n  in  1  asynchronous active-low reset
- iFrameStart  in  1  one-cycle pulse: begin a new histogram
- iFrameEnd  in  1  one-cycle pulse: no more pixels this frame
- iValid  in  1  iPixel valid this cycle
- iPixel  in  PIX_W  pixel luminance
- oReady  out  1  high when pixels are accepted (ACCUM only)
- oRdAddr  out  PIX_W  RAM read-port address
- iRdData  in  CNT_W  RAM read data; registered, 1-cycle latency, old-data on read-during-write
- oWrAddr  out  PIX_W  RAM write-port address
- oWrData  out  CNT_W  RAM write data
- oWrEn  out  1  RAM write enable
- oMaxValue  out  CNT_W  largest bin count of the last completed frame
- oMaxBin  out  PIX_W  bin holding oMaxValue
- oDone  out  1  one-cycle pulse: histogram and max valid
- oBusy  out  1  high in CLEAR, ACCUM and DRAIN

Behaviour:
- Reset (async, iRst_n=0): state IDLE; all outputs 0; pipeline valid bits 0; running max 0. RAM contents are undefined until the next CLEAR.
- States:
  - IDLE: iFrameStart -> CLEAR.
  - CLEAR: oWrEn=1, oWrData=0, oWrAddr counts 0..255, one bin per cycle (256 cycles). Running max is cleared to 0/bin 0. After address 255 -> ACCUM. oReady=0 in CLEAR, so pixels are ignored.
  - ACCUM: oReady=1.
  - DRAIN: entered on iFrameEnd in ACCUM; oReady=0. Waits until both pipeline stages are empty. Then it copies the running max to oMaxValue/oMaxBin, pulses oDone for 1 cycle, and goes to IDLE.
- iFrameStart in any non-IDLE state aborts the frame:
  - in-flight pipeline entries are discarded, with no writes after the abort cycle;
  - oMaxValue/oMaxBin keep their previous-frame values;
  - the state restarts CLEAR at address 0.
- A pixel arriving on the same cycle as iFrameEnd is accepted.
- oMaxValue/oMaxBin change only on the oDone cycle.
- Accumulate pipeline:
  - Cycle t: iValid & oReady -> oRdAddr = iPixel combinationally; stage-1 register takes {valid, addr}.
  - Cycle t+1: count = base + 1, where base = iRdData, or the forwarded value (next bullet). oWrAddr = stage-1 addr, oWrData = count, oWrEn = stage-1 valid, all combinational from stage 1.
  - Forwarding: the write at the end of cycle t+1 collides with a read of the same address at that edge. The last-write register therefore holds {valid, addr, data}. If the current stage-1 addr equals the last-write addr and last-write valid was set the previous cycle, base = last-write data.
  - Latency: pixel accepted at t is in RAM after edge t+2. Throughput: 1 pixel/cycle, unlimited back-to-back same-bin pixels.
- Saturation: if base = 2**CNT_W-1, the written value stays 2**CNT_W-1.
- Max tracking: on every accumulate write, if count > running max (strict), the running max takes {count, addr}. Ties keep the earlier bin.
- Read port address is don't-care when not issuing a read; it holds its last value.

Decomposition:
- Shared package histo_pkg: PIX_W, CNT_W, NUM_BINS, and the state encoding (IDLE, CLEAR, ACCUM, DRAIN). HistogramDisplayer will use the same package.
- Natural sub-module: histo_rmw_pipe, holding the stage-1 register, last-write register, forwarding mux, saturating increment and max compare.
- The FSM, clear counter and output registers stay in the top module.

Test Plan:
- Reset, then iFrameStart: oWrEn=1 for exactly 256 cycles, addresses 0..255, data 0, oReady=0. Then oReady=1 and oBusy=1.
- Stream 0,1,2,...,255 once, then iFrameEnd: every bin reads 1. oDone pulses once, 2 cycles after the last accepted pixel at most. oMaxValue=1, oMaxBin=0 (tie rule).
- 1000 back-to-back pixels of value 7, then 5 pixels of value 200: bin7=1000, bin200=5. oMaxValue=1000, oMaxBin=7. This proves forwarding.
- Alternating 9,9,3,9 with gapped iValid (1,0,1,1,0,1): bin9=3, bin3=1.
- Preload bin 42 to 2**20-2 (CNT_W=20), send 3 pixels of 42: bin 42 = 1048575 and oMaxValue = 1048575.
- Abort and reset mid-frame:
  - iFrameStart mid-ACCUM after 50 pixels: no writes from the old pipeline, CLEAR restarts at 0, oMaxValue unchanged. The next frame's counts are correct.
  - iRst_n low mid-CLEAR: all outputs go to 0 immediately, IDLE.
